mem_read_responder: RTL and testbench
=====================================

Name: mem_read_responder

Overview:
- Word-addressed main-memory model that services the cache fill FSM's word-by-word read requests.
- Also serves writes from the write-through path.
- Accepts one request per cycle and returns each read word with a `data_valid` pulse after a fixed pipelined latency.
- Sits below the I- and D-cache fill FSMs, behind the memory arbiter.

Parameters:
- LATENCY, 4, cycles from request acceptance edge to the cycle `data_valid` is high; legal range 1..8.
- MEM_WORDS, 32768, number of 16-bit words; word index = `addr[15:1]`.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- enable  input  1  request valid this cycle
- wr  input  1  1 = write request, 0 = read request (qualified by `enable`)
- addr  input  16  byte address; `addr[0]` ignored
- data_in  input  16  write data
- data_out  output  16  read data, meaningful only when `data_valid` = 1
- data_valid  output  1  one-cycle pulse per returned read word
- pending  output  4  count of reads accepted but not yet returned
- busy  output  1  `pending` != 0

Behaviour:
- Reset, synchronous, sampled at clock edge with `rst` = 1:
  - all pipeline valid bits cleared
  - `data_valid` = 0, `data_out` = 16'h0000, `pending` = 0, `busy` = 0
  - array contents NOT cleared
  - in-flight reads are dropped and never returned
  - a request presented in the same cycle as `rst` is ignored (no array write, no read issued)
- Write (`enable` = 1, `wr` = 1):
  - `mem[addr[15:1]]` <= `data_in` at that edge
  - no `data_valid`, `pending` unchanged
- Read (`enable` = 1, `wr` = 0):
  - array sampled at the acceptance edge; word and a valid bit enter stage 0 of a LATENCY-deep shift pipeline
  - `data_valid` = 1 and `data_out` = that word exactly LATENCY cycles after acceptance
  - later writes to the same address do not alter the in-flight word (read-before-later-write ordering)
- Pipelined: one read accepted every cycle; back-to-back reads return back-to-back in issue order; gaps preserved.
- `enable` = 0: no array change; pipeline still advances.
- Outputs:
  - `data_out` holds the last returned word when `data_valid` = 0
  - `data_out` and `data_valid` are registered (pipeline last stage), no combinational path from inputs
- `pending` counter:
  - +1 on read accept, -1 on `data_valid`, unchanged when both happen in the same cycle
  - max value LATENCY; never wraps
- Address boundaries:
  - `addr` 16'hFFFE and 16'hFFFF both map to word 32767
  - 16'h0000 and 16'h0001 both map to word 0
  - no out-of-range case at default MEM_WORDS
- Uninitialised array words read as X in simulation; the bench only checks written locations.
- No backpressure: the requester must accept every `data_valid` pulse.

Decomposition:
- Shared package: WORD_W = 16, ADDR_W = 16, DEFAULT_MEM_LATENCY = 4.
  - Same constants used by the fill FSM and the arbiter.
- Sub-module mem_resp_pipe: parameterised LATENCY-stage register chain carrying {valid, 16-bit data}.
  - synchronous reset clears valid bits only
- Top holds the array, the write port, and the `pending` counter.

Test Plan:
- Write 16'hBEEF @ 16'h0010, idle 1 cycle, read 16'h0010 -> `data_valid` exactly 4 cycles after the read edge, `data_out` = 16'hBEEF, `pending` 1 during wait, 0 after.
- Write 16'h1000+i to 16'h0100+2i for i = 0..7, then eight back-to-back reads of the same addresses -> eight consecutive `data_valid` cycles, `data_out` 16'h1000..16'h1007 in order, `pending` peaks at 4.
- Read 16'h0020 (holds 16'hAAAA), next cycle write 16'h5555 to 16'h0020 -> returned word 16'hAAAA; a subsequent read returns 16'h5555.
- Issue 3 reads, assert `rst` 2 cycles later for 1 cycle -> no `data_valid` ever appears for those reads, `pending` = 0 after reset, array contents intact on re-read.
- Read 16'h0021 vs 16'h0020 and 16'hFFFF vs 16'hFFFE -> identical data per pair.
- Reads on alternating cycles (enable 1,0,1,0) -> `data_valid` pattern 1,0,1,0 shifted by 4 cycles; `pending` never exceeds 2.

Source files
------------

// File: rtl/mem_read_responder_pkg.sv
// Shared constants for the memory subsystem (fill FSMs, arbiter, memory model).
// Word-index helper keeps the byte-to-word address mapping in one place.
package mem_read_responder_pkg;

  localparam int WORD_W              = 16;
  localparam int ADDR_W              = 16;
  localparam int DEFAULT_MEM_LATENCY = 4;
  localparam int PEND_W              = 4;

  // Byte address to word index: the low address bit selects a byte and is ignored.
  function automatic logic [ADDR_W-2:0] word_index(input logic [ADDR_W-1:0] byte_addr);
    return byte_addr[ADDR_W-1:1];
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// STAGES-deep register chain carrying {valid, data} for returned read words.
// The last stage is the responder's registered output and holds its word between returns.
module mem_resp_pipe #(
  parameter int STAGES = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              vld_out,
  output logic [DATA_W-1:0] data_out
);

  logic [STAGES-1:0] vld_p;
  logic [DATA_W-1:0] data_p [STAGES];
  logic [STAGES-1:0] vld_src;
  logic [DATA_W-1:0] data_src [STAGES];

  always_comb begin
    vld_src[0]  = vld_in;
    data_src[0] = data_in;
    for (int i = 1; i < STAGES; i++) begin
      vld_src[i]  = vld_p[i-1];
      data_src[i] = data_p[i-1];
    end
  end

  // Data registers load only behind a valid bit, so the last stage keeps the
  // most recently returned word through bubbles; only that stage is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p              <= '0;
      data_p[STAGES-1]   <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        vld_p[i] <= vld_src[i];
        if (vld_src[i]) data_p[i] <= data_src[i];
      end
    end
  end

  assign vld_out  = vld_p[STAGES-1];
  assign data_out = data_p[STAGES-1];

endmodule

// File: rtl/mem_read_responder.sv
// Word-addressed main-memory model: one write or read per cycle, reads returned
// in order after a fixed pipelined latency with a data_valid pulse.
module mem_read_responder
  import mem_read_responder_pkg::*;
#(
  parameter int LATENCY   = DEFAULT_MEM_LATENCY,
  parameter int MEM_WORDS = 32768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic [PEND_W-1:0] pending,
  output logic              busy
);

  logic [WORD_W-1:0] mem [MEM_WORDS];
  logic [ADDR_W-2:0] idx;
  logic              wr_en;
  logic              rd_en;
  logic [WORD_W-1:0] rd_word;
  logic [PEND_W-1:0] pending_p0;

  // A request coinciding with reset is dropped entirely.
  assign idx     = word_index(addr);
  assign wr_en   = enable & wr & ~rst;
  assign rd_en   = enable & ~wr & ~rst;
  assign rd_word = mem[idx];

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= data_in;
  end

  // Read word is captured into stage 0 at the acceptance edge, so a later
  // write to the same location cannot disturb it.
  mem_resp_pipe #(
    .STAGES (LATENCY),
    .DATA_W (WORD_W)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (rd_en),
    .data_in  (rd_word),
    .vld_out  (data_valid),
    .data_out (data_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_p0 <= '0;
    end else begin
      case ({rd_en, data_valid})
        2'b10:   pending_p0 <= pending_p0 + 1'b1;
        2'b01:   pending_p0 <= pending_p0 - 1'b1;
        default: pending_p0 <= pending_p0;
      endcase
    end
  end

  assign pending = pending_p0;
  assign busy    = (pending_p0 != '0);

endmodule

// File: tb/tb_mem_read_responder.sv
// Self-checking bench for mem_read_responder: directed scenarios plus randomized
// traffic, compared against a per-edge reference model of accepted reads.
module tb_mem_read_responder;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_valid;
  logic [3:0]  pending;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: memory contents by word index, reads accepted keyed by edge number.
  logic [15:0] ref_mem [int];
  bit          acc_q   [int];
  logic [15:0] acc_d   [int];
  int          edge_n   = 0;
  int          last_rst = 0;
  bit          exp_valid = 1'b0;
  logic [15:0] exp_dout  = '0;
  int          exp_pend  = 0;

  mem_read_responder #(.LATENCY(L), .MEM_WORDS(32768)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .pending    (pending),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance past the edge, and update expectations.
  task automatic tick(input bit t_rst, input bit en, input bit w,
                      input logic [15:0] a, input logic [15:0] d);
    int k;
    rst = t_rst; enable = en; wr = w; addr = a; data_in = d;
    @(posedge clk);
    edge_n++;
    if (t_rst) begin
      last_rst = edge_n;
      exp_dout = 16'h0000;
    end else if (en && w) begin
      ref_mem[int'(a[15:1])] = d;
    end else if (en) begin
      acc_q[edge_n] = 1'b1;
      acc_d[edge_n] = ref_mem[int'(a[15:1])];
    end
    k = edge_n - L + 1;
    exp_valid = acc_q.exists(k) && (k > last_rst);
    if (exp_valid) exp_dout = acc_d[k];
    exp_pend = 0;
    for (int j = edge_n - L + 1; j <= edge_n; j++)
      if (acc_q.exists(j) && j > last_rst) exp_pend++;
    #1;
  endtask

  task automatic test_reset();
    tick(1, 1, 1, 16'h0040, 16'h1234);
    tick(1, 0, 0, 16'h0000, 16'h0000);
    n_checks += 4;
    if (data_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", data_valid); else n_pass++;
    if (data_out !== 16'h0000) $display("FAIL reset_dout got %h want 0000", data_out); else n_pass++;
    if (pending !== 4'd0) $display("FAIL reset_pending got %0d want 0", pending); else n_pass++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single_read();
    tick(0, 1, 1, 16'h0010, 16'hBEEF);
    tick(0, 0, 0, 16'h0000, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) tick(0, 1, 0, 16'h0010, 16'h0000);
      else        tick(0, 0, 0, 16'h0000, 16'h0000);
      n_checks += 3;
      if (data_valid !== (i == 3)) $display("FAIL single_valid i=%0d got %b want %b", i, data_valid, (i == 3)); else n_pass++;
      if (pending !== ((i <= 3) ? 4'd1 : 4'd0)) $display("FAIL single_pending i=%0d got %0d", i, pending); else n_pass++;
      if (i >= 3 && data_out !== 16'hBEEF) $display("FAIL single_dout i=%0d got %h want beef", i, data_out); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got_q[$];
    int peak = 0;
    for (int i = 0; i < 8; i++) tick(0, 1, 1, 16'h0100 + 16'(2*i), 16'h1000 + 16'(i));
    for (int i = 0; i < 14; i++) begin
      if (i < 8) tick(0, 1, 0, 16'h0100 + 16'(2*i), 16'h0000);
      else       tick(0, 0, 0, 16'h0000, 16'h0000);
      if (data_valid === 1'b1) got_q.push_back(data_out);
      if (int'(pending) > peak) peak = int'(pending);
      n_checks += 3;
      if (data_valid !== exp_valid) $display("FAIL b2b_valid i=%0d got %b want %b", i, data_valid, exp_valid); else n_pass++;
      if (data_out !== exp_dout) $display("FAIL b2b_dout i=%0d got %h want %h", i, data_out, exp_dout); else n_pass++;
      if (int'(pending) !== exp_pend) $display("FAIL b2b_pending i=%0d got %0d want %0d", i, pending, exp_pend); else n_pass++;
    end
    n_checks += 2;
    if (got_q.size() !== 8) $display("FAIL b2b_count got %0d want 8", got_q.size()); else n_pass++;
    if (peak !== 4) $display("FAIL b2b_peak got %0d want 4", peak); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== 16'h1000 + 16'(i)) $display("FAIL b2b_order i=%0d got %h want %h", i, got_q[i], 16'h1000 + 16'(i)); else n_pass++;
    end
  endtask

  task automatic test_read_before_write();
    logic [15:0] got_q[$];
    tick(0, 1, 1, 16'h0020, 16'hAAAA);
    tick(0, 1, 0, 16'h0020, 16'h0000);
    tick(0, 1, 1, 16'h0020, 16'h5555);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) tick(0, 1, 0, 16'h0020, 16'h0000);
      else        tick(0, 0, 0, 16'h0000, 16'h0000);
      if (data_valid === 1'b1) got_q.push_back(data_out);
      n_checks += 2;
      if (data_valid !== exp_valid) $display("FAIL rbw_valid i=%0d got %b want %b", i, data_valid, exp_valid); else n_pass++;
      if (data_out !== exp_dout) $display("FAIL rbw_dout i=%0d got %h want %h", i, data_out, exp_dout); else n_pass++;
    end
    n_checks += 2;
    if (got_q.size() !== 2) $display("FAIL rbw_count got %0d want 2", got_q.size());
    else n_pass++;
    if (got_q.size() == 2 && (got_q[0] !== 16'hAAAA || got_q[1] !== 16'h5555))
      $display("FAIL rbw_words got %h,%h want aaaa,5555", got_q[0], got_q[1]);
    else n_pass++;
  endtask

  task automatic test_reset_flush();
    int nvalid = 0;
    tick(0, 1, 1, 16'h0200, 16'hC0DE);
    tick(0, 1, 0, 16'h0200, 16'h0000);
    tick(0, 1, 0, 16'h0200, 16'h0000);
    tick(0, 1, 0, 16'h0200, 16'h0000);
    tick(1, 0, 0, 16'h0000, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, 16'h0000, 16'h0000);
      if (data_valid === 1'b1) nvalid++;
    end
    n_checks += 4;
    if (nvalid !== 0) $display("FAIL flush_valid got %0d pulses want 0", nvalid); else n_pass++;
    if (pending !== 4'd0) $display("FAIL flush_pending got %0d want 0", pending); else n_pass++;
    if (data_out !== 16'h0000) $display("FAIL flush_dout got %h want 0000", data_out); else n_pass++;
    tick(0, 1, 0, 16'h0200, 16'h0000);
    for (int i = 0; i < L - 1; i++) tick(0, 0, 0, 16'h0000, 16'h0000);
    if (data_valid !== 1'b1 || data_out !== 16'hC0DE)
      $display("FAIL flush_reread got %b/%h want 1/c0de", data_valid, data_out);
    else n_pass++;
  endtask

  task automatic test_addr_alias();
    logic [15:0] pair_a [3] = '{16'h0021, 16'hFFFF, 16'h0001};
    logic [15:0] pair_b [3] = '{16'h0020, 16'hFFFE, 16'h0000};
    logic [15:0] vals   [3] = '{16'h1357, 16'h2468, 16'h9ABC};
    for (int p = 0; p < 3; p++) begin
      logic [15:0] got_q[$];
      tick(0, 1, 1, pair_b[p], vals[p]);
      tick(0, 1, 0, pair_a[p], 16'h0000);
      tick(0, 1, 0, pair_b[p], 16'h0000);
      for (int i = 0; i < L + 1; i++) begin
        tick(0, 0, 0, 16'h0000, 16'h0000);
        if (data_valid === 1'b1) got_q.push_back(data_out);
      end
      n_checks += 2;
      if (got_q.size() !== 2) $display("FAIL alias_count p=%0d got %0d want 2", p, got_q.size()); else n_pass++;
      if (got_q.size() == 2 && (got_q[0] !== vals[p] || got_q[1] !== vals[p]))
        $display("FAIL alias_data p=%0d got %h,%h want %h", p, got_q[0], got_q[1], vals[p]);
      else n_pass++;
    end
  endtask

  task automatic test_alternating();
    int over = 0;
    for (int i = 0; i < 4; i++) tick(0, 1, 1, 16'h0300 + 16'(2*i), 16'h7000 + 16'(i));
    for (int i = 0; i < 14; i++) begin
      if (i < 8 && i % 2 == 0) tick(0, 1, 0, 16'h0300 + 16'(i), 16'h0000);
      else                     tick(0, 0, 0, 16'h0000, 16'h0000);
      if (pending > 4'd2) over++;
      n_checks += 2;
      if (data_valid !== ((i >= 3) && (i <= 9) && ((i - 3) % 2 == 0)))
        $display("FAIL alt_valid i=%0d got %b", i, data_valid);
      else n_pass++;
      if (data_out !== exp_dout) $display("FAIL alt_dout i=%0d got %h want %h", i, data_out, exp_dout); else n_pass++;
    end
    n_checks++;
    if (over !== 0) $display("FAIL alt_pending_max exceeded 2 in %0d cycles", over); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] wq[$];
    for (int i = 0; i < 12; i++) begin
      logic [15:0] a = 16'($urandom);
      wq.push_back(a);
      tick(0, 1, 1, a, 16'($urandom));
    end
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 24);
      logic [15:0] a = wq[$urandom_range(0, wq.size() - 1)] ^ 16'($urandom_range(0, 1));
      if (r == 0)      tick(1, $urandom_range(0, 1), 0, a, 16'h0000);
      else if (r < 7)  tick(0, 1, 1, a, 16'($urandom));
      else if (r < 18) tick(0, 1, 0, a, 16'h0000);
      else             tick(0, 0, $urandom_range(0, 1), a, 16'($urandom));
      n_checks += 4;
      if (data_valid !== exp_valid) $display("FAIL rnd_valid i=%0d got %b want %b", i, data_valid, exp_valid); else n_pass++;
      if (data_out !== exp_dout) $display("FAIL rnd_dout i=%0d got %h want %h", i, data_out, exp_dout); else n_pass++;
      if (int'(pending) !== exp_pend) $display("FAIL rnd_pending i=%0d got %0d want %0d", i, pending, exp_pend); else n_pass++;
      if (busy !== (exp_pend != 0)) $display("FAIL rnd_busy i=%0d got %b want %b", i, busy, (exp_pend != 0)); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_read_before_write();
    test_reset_flush();
    test_addr_alias();
    test_alternating();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
